// File: rtl/ysyx_24090012_axi_sram_slave.sv
// AXI4 SRAM responder: word-addressed memory with configurable read latency,
// FIXED/INCR bursts, byte strobes and write-over-read arbitration in IDLE.
module ysyx_24090012_axi_sram_slave #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_WAIT, R_DATA} state_t;

  function automatic logic [1:0] resp_code(input logic dec, input logic slv);
    return dec ? DECERR : (slv ? SLVERR : OKAY);
  endfunction

  state_t      state, state_nxt;
  logic        rst_q;
  logic [31:0] addr_r;
  logic [3:0]  id_r;
  logic [7:0]  len_r, cnt_r;
  logic [3:0]  lat_r;
  logic        incr_r, slv_r, dec_r, wrap_r;
  logic [31:0] mem [2**DEPTH_LOG2];

  logic        quiet, aw_hs, ar_hs, w_hs, r_hs;
  logic        last_beat, beat_dec, w_slv, w_en, addr_carry;
  logic [31:0] addr_off, addr_inc;
  logic [1:0]  r_resp;
  logic [DEPTH_LOG2-1:0] word_idx;

  // Outputs stay silent during reset and the cycle after it.
  assign quiet      = rst | rst_q;
  assign aw_hs      = awvalid & awready;
  assign ar_hs      = arvalid & arready;
  assign w_hs       = wvalid & wready;
  assign r_hs       = rvalid & rready;
  assign last_beat  = (cnt_r == len_r);
  assign addr_off   = addr_r - BASE;
  assign word_idx   = addr_off[DEPTH_LOG2+1:2];
  assign {addr_carry, addr_inc} = {1'b0, addr_r} + 33'd4;
  assign beat_dec   = wrap_r || (addr_r < BASE) || ((addr_off >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_slv      = (wlast != last_beat);
  assign w_en       = w_hs & ~(dec_r | slv_r | beat_dec | w_slv);
  assign r_resp     = resp_code(beat_dec, slv_r);

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = OKAY;
    bid       = '0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = OKAY;
    rlast     = 1'b0;
    rid       = '0;
    if (!quiet) begin
      case (state)
        IDLE: begin
          awready = 1'b1;
          arready = !awvalid;
          if (awvalid)      state_nxt = W_DATA;
          else if (arvalid) state_nxt = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid && last_beat) state_nxt = W_RESP;
        end
        W_RESP: begin
          bvalid = 1'b1;
          bid    = id_r;
          bresp  = resp_code(dec_r, slv_r);
          if (bready) state_nxt = IDLE;
        end
        R_WAIT: begin
          if (lat_r <= 4'd1) state_nxt = R_DATA;
        end
        R_DATA: begin
          rvalid = 1'b1;
          rid    = id_r;
          rresp  = r_resp;
          rlast  = last_beat;
          rdata  = (r_resp == OKAY) ? mem[word_idx] : '0;
          if (rready && last_beat) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Transaction context; size/burst errors are known up front, the rest accrue per beat.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      addr_r <= awaddr;
      id_r   <= awid;
      len_r  <= awlen;
      cnt_r  <= '0;
      incr_r <= (awburst == 2'b01);
      slv_r  <= (awsize > 3'd2) || awburst[1];
      dec_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else if (ar_hs) begin
      addr_r <= araddr;
      id_r   <= arid;
      len_r  <= arlen;
      cnt_r  <= '0;
      incr_r <= (arburst == 2'b01);
      slv_r  <= (arsize > 3'd2) || arburst[1];
      dec_r  <= 1'b0;
      wrap_r <= 1'b0;
      lat_r  <= 4'(RD_LATENCY);
    end else if (w_hs || r_hs) begin
      cnt_r <= cnt_r + 8'd1;
      if (incr_r) begin
        addr_r <= addr_inc;
        wrap_r <= wrap_r | addr_carry;
      end
      if (w_hs) begin
        dec_r <= dec_r | beat_dec;
        slv_r <= slv_r | w_slv;
      end
    end else if (state == R_WAIT) begin
      lat_r <= lat_r - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_axi_sram_slave.sv
// Scoreboard bench for the AXI SRAM responder: directed scenarios plus random
// traffic, checked against a byte-level memory model kept in the bench.
module tb_ysyx_24090012_axi_sram_slave;

  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam int          DEPTH_LOG2 = 16;
  localparam int          RD_LATENCY = 2;
  localparam logic [63:0] LO         = {32'd0, BASE};
  localparam logic [63:0] HI         = LO + 64'(4 * (2 ** DEPTH_LOG2));
  localparam logic [31:0] POOL       = 32'h8000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, arvalid, arready, wvalid, wready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        wlast, bvalid, bready, rvalid, rready, rlast;

  ysyx_24090012_axi_sram_slave #(
    .BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; bit known; } rexp_t;

  bexp_t       b_exp[$];
  rexp_t       r_exp[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] mm [int unsigned];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_ar_cyc = 0;
  int last_b_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name, input string why);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, why);
  endfunction

  function automatic logic [63:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int k);
    return {32'd0, addr} + ((burst == 2'b01) ? 64'(4 * k) : 64'd0);
  endfunction

  // Memory model: writes land only while the transaction is still error-free.
  function automatic void model_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                                      input logic [1:0] burst, input logic [2:0] size, input int last_at);
    bit dec, slv;
    logic [63:0] a;
    logic [31:0] w;
    int unsigned idx;
    bexp_t e;
    dec = 0;
    slv = (size > 3'd2) || (burst > 2'd1);
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, burst, k);
      if (a < LO || a >= HI) dec = 1;
      if ((k == last_at) != (k == int'(len))) slv = 1;
      if (!dec && !slv) begin
        idx = 32'((a - LO) >> 2);
        w = mm.exists(idx) ? mm[idx] : 32'd0;
        for (int b = 0; b < 4; b++) if (ws_q[k][b]) w[8*b +: 8] = wd_q[k][8*b +: 8];
        mm[idx] = w;
      end
    end
    e.id = id;
    e.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    b_exp.push_back(e);
  endfunction

  function automatic void model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] size);
    bit slv;
    logic [63:0] a;
    int unsigned idx;
    rexp_t e;
    slv = (size > 3'd2) || (burst > 2'd1);
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, burst, k);
      idx = 32'((a - LO) >> 2);
      e.id = id;
      e.last = (k == int'(len));
      e.resp = (a < LO || a >= HI) ? 2'b11 : (slv ? 2'b10 : 2'b00);
      e.known = (e.resp != 2'b00) || mm.exists(idx);
      e.data = (e.resp == 2'b00 && mm.exists(idx)) ? mm[idx] : 32'd0;
      r_exp.push_back(e);
    end
  endfunction

  task automatic drive_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int last_at);
    int t;
    awvalid = 1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 200);
    if (!awready) begin
      flag("aw_handshake", "timeout");
      awvalid = 0; wd_q.delete(); ws_q.delete(); b_exp.delete();
      return;
    end
    @(posedge clk); #1 awvalid = 0;
    for (int k = 0; k <= int'(len); k++) begin
      wvalid = 1; wdata = wd_q.pop_front(); wstrb = ws_q.pop_front(); wlast = (k == last_at);
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      if (k == 0) chk("wready_first_beat", 64'(t), 64'd1);
      if (!wready) begin flag("w_handshake", "timeout"); break; end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    @(negedge clk);
    chk("bvalid_after_last_w", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
    t = 0;
    while (b_exp.size() != 0 && t < 100) begin
      bready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      t++;
    end
    bready = 0;
    if (b_exp.size() != 0) begin flag("b_handshake", "timeout"); b_exp.delete(); end
  endtask

  task automatic drive_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode);
    int t, ph;
    bit seen;
    arvalid = 1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 200);
    if (!arready) begin flag("ar_handshake", "timeout"); arvalid = 0; r_exp.delete(); return; end
    last_ar_cyc = cyc;
    @(posedge clk); #1 arvalid = 0;
    seen = 0; ph = 0; t = 0;
    while (r_exp.size() != 0 && t < 400) begin
      case (mode)
        0:       rready = 1;
        1:       rready = seen ? (ph % 2 == 0) : 1'b1;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (!seen && rvalid) begin
        seen = 1;
        chk("r_first_latency", 64'(cyc - last_ar_cyc), 64'(1 + RD_LATENCY));
      end
      @(posedge clk); #1;
      t++;
      if (seen) ph++;
    end
    rready = 0;
    if (r_exp.size() != 0) begin flag("r_beats", "timeout"); r_exp.delete(); end
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    wd_q.push_back(d);
    ws_q.push_back(s);
  endtask

  task automatic op_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int last_at);
    model_write(addr, id, len, burst, size, last_at);
    drive_write(addr, id, len, burst, size, last_at);
  endtask

  task automatic op_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode);
    model_read(addr, id, len, burst, size);
    drive_read(addr, id, len, burst, size, mode);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_handshake_outs"}, 64'({awready, arready, wready, bvalid, rvalid}), 64'd0);
    chk({tag, "_payload_outs"}, 64'({rdata, rresp, rlast, rid, bresp, bid}), 64'd0);
  endtask

  // Monitor: pops expectations on every response handshake, and checks R hold under stall.
  bit          stall_vld = 0;
  logic [38:0] stall_snap;
  always @(negedge clk) begin
    if (rst) begin
      stall_vld = 0;
    end else begin
      if (bvalid && bready) begin
        last_b_cyc = cyc;
        if (b_exp.size() == 0) flag("b_unexpected", "response with nothing outstanding");
        else begin
          bexp_t be;
          be = b_exp.pop_front();
          chk("bid", 64'(bid), 64'(be.id));
          chk("bresp", 64'(bresp), 64'(be.resp));
        end
      end
      if (rvalid) begin
        if (stall_vld) chk("r_stable", 64'({rdata, rresp, rlast, rid}), 64'(stall_snap));
        if (rready) begin
          stall_vld = 0;
          if (r_exp.size() == 0) flag("r_unexpected", "beat with nothing outstanding");
          else begin
            rexp_t re;
            re = r_exp.pop_front();
            if (re.known) chk("rdata", 64'(rdata), 64'(re.data));
            chk("rresp", 64'(rresp), 64'(re.resp));
            chk("rlast", 64'(rlast), 64'(re.last));
            chk("rid", 64'(rid), 64'(re.id));
          end
        end else begin
          stall_vld = 1;
          stall_snap = {rdata, rresp, rlast, rid};
        end
      end else begin
        if (stall_vld) chk("rvalid_held_in_stall", 64'(rvalid), 64'd1);
        stall_vld = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1; awvalid = 0; arvalid = 0; wvalid = 0; bready = 0; rready = 0; wlast = 0;
    awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) check_quiet("reset_hold");
    @(posedge clk); #1 rst = 0;
    @(negedge clk) check_quiet("reset_after");
    @(negedge clk) chk("idle_readies", 64'({awready, arready}), 64'b11);
    @(posedge clk); #1;

    // Single write then read.
    push_w(32'hDEADBEEF, 4'hF);
    op_write(32'h8000_0010, 4'h1, 8'd0, 2'b01, 3'd2, 0);
    op_read(32'h8000_0010, 4'h2, 8'd0, 2'b01, 3'd2, 0);

    // Strobe merge.
    push_w(32'h11223344, 4'hF);
    op_write(32'h8000_0020, 4'h3, 8'd0, 2'b01, 3'd2, 0);
    push_w(32'hAABBCCDD, 4'b0101);
    op_write(32'h8000_0020, 4'h3, 8'd0, 2'b00, 3'd2, 0);
    op_read(32'h8000_0020, 4'h4, 8'd0, 2'b01, 3'd2, 0);

    // INCR burst, read back with rready toggling.
    for (int k = 1; k <= 4; k++) push_w(32'(k), 4'hF);
    op_write(32'h8000_0100, 4'h5, 8'd3, 2'b01, 3'd2, 3);
    op_read(32'h8000_0100, 4'hA, 8'd3, 2'b01, 3'd2, 1);

    // Simultaneous AW and AR: write first, AR right after the B handshake.
    push_w(32'h5555AAAA, 4'hF);
    model_write(32'h8000_0030, 4'h6, 8'd0, 2'b01, 3'd2, 0);
    model_read(32'h8000_0030, 4'h7, 8'd0, 2'b01, 3'd2);
    fork
      drive_write(32'h8000_0030, 4'h6, 8'd0, 2'b01, 3'd2, 0);
      drive_read(32'h8000_0030, 4'h7, 8'd0, 2'b01, 3'd2, 0);
    join
    chk("ar_cycle_after_b", 64'(last_ar_cyc), 64'(last_b_cyc + 1));

    // Out-of-range read and address wrap.
    op_read(32'h0000_0000, 4'h8, 8'd1, 2'b01, 3'd2, 0);
    op_read(32'hFFFF_FFF8, 4'h9, 8'd2, 2'b01, 3'd2, 2);

    // Burst straddling the top of memory: first beat lands, second is DECERR.
    push_w(32'hCAFEF00D, 4'hF); push_w(32'h0BADF00D, 4'hF);
    op_write(32'h8003_FFFC, 4'hB, 8'd1, 2'b01, 3'd2, 1);
    op_read(32'h8003_FFFC, 4'hC, 8'd1, 2'b01, 3'd2, 0);

    // Early wlast: three beats consumed, SLVERR, memory untouched.
    push_w(32'hA0A0A0A0, 4'hF); push_w(32'hA1A1A1A1, 4'hF); push_w(32'hA2A2A2A2, 4'hF);
    op_write(32'h8000_0040, 4'hD, 8'd2, 2'b01, 3'd2, 2);
    push_w(32'h12345678, 4'h0); push_w(32'h9ABCDEF0, 4'hF); push_w(32'h0F0F0F0F, 4'hF);
    op_write(32'h8000_0040, 4'hE, 8'd2, 2'b01, 3'd2, 1);
    op_read(32'h8000_0040, 4'hF, 8'd2, 2'b01, 3'd2, 2);

    // Size and burst-type errors.
    push_w(32'hFFFFFFFF, 4'hF);
    op_write(32'h8000_0010, 4'h1, 8'd0, 2'b01, 3'd3, 0);
    push_w(32'hFFFFFFFF, 4'hF);
    op_write(32'h8000_0010, 4'h2, 8'd0, 2'b10, 3'd2, 0);
    op_read(32'h8000_0010, 4'h3, 8'd0, 2'b01, 3'd3, 0);
    op_read(32'h8000_0010, 4'h4, 8'd0, 2'b11, 3'd2, 0);
    op_read(32'h8000_0010, 4'h5, 8'd0, 2'b00, 3'd2, 0);

    // Reset while beat 2 of 4 is presented.
    model_read(32'h8000_0100, 4'h6, 8'd3, 2'b01, 3'd2);
    arvalid = 1; araddr = 32'h8000_0100; arid = 4'h6; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 50);
    if (!arready) flag("rst_test_ar", "timeout");
    @(posedge clk); #1 arvalid = 0; rready = 1;
    t = 0;
    while (r_exp.size() > 3 && t < 50) begin @(posedge clk); #1; t++; end
    if (r_exp.size() > 3) flag("rst_test_beat1", "timeout");
    rready = 0; rst = 1;
    @(negedge clk) check_quiet("reset_mid_burst");
    @(posedge clk); #1 rst = 0; r_exp.delete();
    @(negedge clk) check_quiet("reset_mid_burst_after");
    @(posedge clk); #1;
    op_read(32'h8000_0100, 4'h7, 8'd3, 2'b01, 3'd2, 2);

    // Random traffic over a preloaded pool, including misaligned starts.
    for (int k = 0; k < 16; k++) push_w($urandom, 4'hF);
    op_write(POOL, 4'h0, 8'd15, 2'b01, 3'd2, 15);
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [31:0] a;
      logic [3:0]  id;
      int          s;
      len   = 8'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 1));
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2;
      s     = (burst == 2'b01) ? int'($urandom_range(0, 15 - int'(len))) : int'($urandom_range(0, 15));
      a     = POOL + 32'(4 * s) + 32'($urandom_range(0, 3));
      id    = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= int'(len); k++) push_w($urandom, 4'($urandom));
        op_write(a, id, len, burst, size, int'(len));
      end else begin
        op_read(a, id, len, burst, size, int'($urandom_range(0, 2)));
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24090012_axi_sram_slave.md
# ysyx_24090012_axi_sram_slave

AXI4 responder that terminates the arbiter's `io_master_*` bus in simulation and in SoC-less builds. It models a word-addressed SRAM with configurable read latency and serves one transaction at a time. It supports FIXED/INCR bursts with byte strobes and follows the same write-over-read priority as the upstream arbiter. It replaces the DPI memory stub behind the IFU/LSU arbiter.

## Interface
- `BASE`, 32'h8000_0000, byte address of word 0; must be 4-byte aligned.
- `DEPTH_LOG2`, 16, memory holds 2^DEPTH_LOG2 32-bit words.
- `RD_LATENCY`, 2, idle cycles between AR handshake and first R beat; 0..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `awvalid`, `arvalid`, `wvalid`  input  1  channel valids from the master.
- `awready`, `arready`, `wready`  output  1  channel readies to the master.
- `awaddr`, `araddr`  input  32  byte start address.
- `awid`, `arid`  input  4  transaction ID; echoed on `bid`/`rid`.
- `awlen`, `arlen`  input  8  beats minus 1.
- `awsize`, `arsize`  input  3  beat size; values above 3'b010 are errors.
- `awburst`, `arburst`  input  2  00 FIXED, 01 INCR; 10/11 are errors.
- `wdata`  input  32  write data.
- `wstrb`  input  4  byte enables; bit i writes `wdata[8i+7:8i]`.
- `wlast`  input  1  master's last-beat marker.
- `bvalid`  output  1  write response valid.
- `bready`  input  1  write response accept.
- `bresp`  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
- `bid`  output  4  latched `awid`.
- `rvalid`  output  1  read beat valid.
- `rready`  input  1  read beat accept.
- `rdata`  output  32  read data.
- `rresp`  output  2  per-beat response, same encoding as `bresp`.
- `rlast`  output  1  high on beat `arlen`.
- `rid`  output  4  latched `arid`.

## Operation
- States: IDLE, W_DATA, W_RESP, R_WAIT, R_DATA. Memory contents are not cleared by reset.
- IDLE: `awready`=1 and `arready`=!`awvalid`.
  - AW handshake: latch addr/id/len/size/burst, clear beat count, go to W_DATA.
  - AR handshake without awvalid: latch the same fields, load latency counter = `RD_LATENCY`, go to R_WAIT; if `RD_LATENCY`=0 go straight to R_DATA.
  - Both valid in the same cycle: the write wins; AR stays pending and is accepted on the next return to IDLE.
- W_DATA: `wready`=1.
  - Each handshake writes strobed bytes to word `(addr-BASE)>>2` only if the transaction has no error.
  - INCR adds 4 to addr per beat; FIXED holds addr.
  - Error flags: DECERR if any beat's address is outside [BASE, BASE+4·2^DEPTH_LOG2); SLVERR if size>2, burst is 10/11, or `wlast` disagrees with (count==len) on any beat. DECERR outranks SLVERR.
  - After beat count == len, go to W_RESP. `wlast` never terminates the burst early.
- W_RESP: `bvalid`=1 with `bid` and sticky `bresp`, held stable until `bready`, then return to IDLE.
- R_WAIT: decrement the counter each cycle; enter R_DATA when it reaches 0.
- R_DATA: `rvalid`=1.
  - `rdata` = mem word, or 0 if the beat is out of range or the transaction is SLVERR.
  - `rresp` is evaluated per beat.
  - `rlast` = (count==len).
  - All R outputs stay stable while `rready`=0.
  - On each handshake, advance addr/count; after the last beat, return to IDLE.
- Misaligned addresses: bits [1:0] are ignored for indexing.

## Timing
- While `rst`=1 and in the cycle after: all valid/ready outputs 0; `rdata`, `rresp`, `rlast`, `rid`, `bresp`, `bid` = 0; state IDLE.
- Write: AW handshake at cycle T; first W beat can be accepted at T+1; one beat per cycle; `bvalid` rises the cycle after the last W handshake.
- Read: AR handshake at T; first `rvalid` at T+1+`RD_LATENCY`; subsequent beats back-to-back while `rready`=1.
- No new AW/AR is accepted until the current response completes; readies are 0 outside IDLE.
- Reset mid-burst abandons the transaction with no response. Words already written stay written.
- Address wrap past 32'hFFFF_FFFC is modulo 2^32; the wrapped beat gets DECERR.

## Test plan
- Single write then read: AW 0x8000_0010, wdata 0xDEADBEEF, wstrb 0xF, then AR 0x8000_0010 len 0 -> bresp 00; rdata 0xDEADBEEF, rlast=1, first rvalid exactly 3 cycles after the AR handshake.
- Strobe merge: preload 0x11223344, then write 0xAABBCCDD with wstrb 0b0101 -> readback 0x11BB33DD.
- INCR burst len 3 write at 0x8000_0100 with data 1,2,3,4, then read len 3 with `rready` toggled 1,0,1,0 -> data 1..4 in order, held stable while stalled, `rlast` only on beat 4, `rid` = `arid`.
- Simultaneous AW and AR in IDLE -> write completes first; AR accepted the cycle after the B handshake; read returns the new data.
- Out-of-range AR 0x0000_0000 len 1 -> two beats with rdata 0 and rresp 11. A write with `wlast` on beat 1 of len 2 -> 3 beats consumed, bresp 10, memory unchanged.
- Assert reset during R_DATA beat 2 of 4 -> the next cycle all valid/ready outputs are 0; a new AR after reset is served normally.
